wr_page_ram_256x8bit: RTL and testbench

//  True dual-port synchronous RAM, 256 x 8 bit, holding one flash page for the x1 SPI controller.

---
 rtl/wr_page_ram_pkg.sv | 8 +
 rtl/wr_page_ram_oreg.sv | 17 +
 rtl/wr_page_ram_256x8bit.sv | 48 ++++
 tb/tb_wr_page_ram_256x8bit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/wr_page_ram_pkg.sv
// wr_page_ram_pkg: shared widths and types for the page buffer RAM
package wr_page_ram_pkg;
    localparam int WRPAGE_DATA_W = 8;
    localparam int WRPAGE_ADDR_W = 8;
    localparam int WRPAGE_DEPTH  = 2 ** WRPAGE_ADDR_W;
    typedef logic [WRPAGE_ADDR_W-1:0] wrpage_addr_t;
    typedef logic [WRPAGE_DATA_W-1:0] wrpage_data_t;
endpackage

// File: rtl/wr_page_ram_oreg.sv
// wr_page_ram_oreg: per-port read data register, asynchronously cleared by rst_n
module wr_page_ram_oreg
    import wr_page_ram_pkg::*;
#(
    parameter int W = WRPAGE_DATA_W
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // capture read data each edge; reset forces zero immediately
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= d;
    end
endmodule

// File: rtl/wr_page_ram_256x8bit.sv
// wr_page_ram_256x8bit: true dual-port 256x8 page buffer; WRPAGE_RAM_OUTREG_EN adds a second output stage
module wr_page_ram_256x8bit
    import wr_page_ram_pkg::*;
#(
    parameter int DATA_W = WRPAGE_DATA_W,
    parameter int ADDR_W = WRPAGE_ADDR_W
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              wren_a,
    output logic [DATA_W-1:0] q_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] data_b,
    input  logic              wren_b,
    output logic [DATA_W-1:0] q_b
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_a, rd_b, s_a, s_b;

    // array writes; B first so A overrides it when both hit the same word
    always_ff @(posedge clock) begin
        if (wren_b) mem[address_b] <= data_b;
        if (wren_a) mem[address_a] <= data_a;
    end

    // port A read: own write passes through, otherwise the pre-edge contents
    always_comb begin
        rd_a = wren_a ? data_a : mem[address_a];
    end

    // port B read: same rule, so it sees old data when only A writes the word
    always_comb begin
        rd_b = wren_b ? data_b : mem[address_b];
    end

    wr_page_ram_oreg #(.W(DATA_W)) u_oreg_a1 (.clock(clock), .rst_n(rst_n), .d(rd_a), .q(s_a));
    wr_page_ram_oreg #(.W(DATA_W)) u_oreg_b1 (.clock(clock), .rst_n(rst_n), .d(rd_b), .q(s_b));

`ifdef WRPAGE_RAM_OUTREG_EN
    wr_page_ram_oreg #(.W(DATA_W)) u_oreg_a2 (.clock(clock), .rst_n(rst_n), .d(s_a), .q(q_a));
    wr_page_ram_oreg #(.W(DATA_W)) u_oreg_b2 (.clock(clock), .rst_n(rst_n), .d(s_b), .q(q_b));
`else
    assign q_a = s_a;
    assign q_b = s_b;
`endif
endmodule

// File: tb/tb_wr_page_ram_256x8bit.sv
// tb_wr_page_ram_256x8bit: scoreboard bench for the dual-port page buffer
module tb_wr_page_ram_256x8bit;
`ifdef WRPAGE_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    typedef struct {
        int         due;
        logic [7:0] val;
    } exp_t;

    logic       clock = 0;
    logic       rst_n = 1;
    logic [7:0] address_a = 0, data_a = 0, address_b = 0, data_b = 0;
    logic       wren_a = 0, wren_b = 0;
    logic [7:0] q_a, q_b;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       qa[$];
    exp_t       qb[$];

    wr_page_ram_256x8bit dut (
        .clock(clock), .rst_n(rst_n),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .q_a(q_a),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .q_b(q_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // monitor: compare each queued expectation on the cycle it falls due
    always @(negedge clock) begin
        if (qa.size() > 0 && qa[0].due <= cyc) begin
            checks++;
            if (qa[0].due != cyc || q_a !== qa[0].val) begin
                errors++;
                $display("FAIL q_a cyc=%0d due=%0d got %h want %h", cyc, qa[0].due, q_a, qa[0].val);
            end
            void'(qa.pop_front());
        end
        if (qb.size() > 0 && qb[0].due <= cyc) begin
            checks++;
            if (qb[0].due != cyc || q_b !== qb[0].val) begin
                errors++;
                $display("FAIL q_b cyc=%0d due=%0d got %h want %h", cyc, qb[0].due, q_b, qb[0].val);
            end
            void'(qb.pop_front());
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // one cycle of stimulus on both ports; ca/cb push an expected read result
    task automatic op(input logic [7:0] aa, input logic [7:0] da, input logic wa,
                      input logic ca, input logic [7:0] ea,
                      input logic [7:0] ab, input logic [7:0] db, input logic wb,
                      input logic cb, input logic [7:0] eb);
        exp_t e;
        address_a = aa; data_a = da; wren_a = wa;
        address_b = ab; data_b = db; wren_b = wb;
        e.due = cyc + LAT;
        if (ca) begin e.val = ea; qa.push_back(e); end
        if (cb) begin e.val = eb; qb.push_back(e); end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        op(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic drain();
        for (int k = 0; k < LAT + 2; k++) idle();
    endtask

    initial begin
        #1 rst_n = 0;
        // test 1: random inputs during reset keep outputs at zero
        for (int i = 0; i < 4; i++) begin
            address_a = 8'($urandom); data_a = 8'($urandom); wren_a = 1'($urandom);
            address_b = 8'($urandom); data_b = 8'($urandom); wren_b = 1'($urandom);
            @(posedge clock);
            #1;
            chk("reset_q_a", q_a, 8'h00);
            chk("reset_q_b", q_b, 8'h00);
        end
        rst_n = 1;
        op(8'h10, 8'h5A, 1'b1, 1'b1, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        drain();
        #1 rst_n = 0;
        #1 chk("reset_async_q_a", q_a, 8'h00);
        @(posedge clock);
        #1 rst_n = 1;
        op(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h10, 8'h00, 1'b0, 1'b1, 8'h5A);
        drain();
        // test 2: fill via A (write-through on q_a), then drain via B
        for (int i = 0; i < 256; i++)
            op(8'(i), 8'(i) ^ 8'hA5, 1'b1, 1'b1, 8'(i) ^ 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        drain();
        for (int i = 0; i < 100; i++)
            op(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'(i), 8'h00, 1'b0, 1'b1, 8'(i) ^ 8'hA5);
        // test 6: async reset between edges mid-burst
        #1 rst_n = 0;
        #1 chk("midburst_async_q_b", q_b, 8'h00);
        qa.delete();
        qb.delete();
        @(posedge clock);
        #1 chk("midburst_hold_q_b", q_b, 8'h00);
        rst_n = 1;
        for (int i = 96; i < 256; i++)
            op(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'(i), 8'h00, 1'b0, 1'b1, 8'(i) ^ 8'hA5);
        drain();
        // test 3: same-port write-through
        op(8'h20, 8'h11, 1'b1, 1'b1, 8'h11, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        op(8'h20, 8'h3C, 1'b1, 1'b1, 8'h3C, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        op(8'h20, 8'h00, 1'b0, 1'b1, 8'h3C, 8'h20, 8'h00, 1'b0, 1'b1, 8'h3C);
        drain();
        // test 4: mixed-port collision, B sees old then new
        op(8'h40, 8'h11, 1'b1, 1'b1, 8'h11, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        op(8'h40, 8'h99, 1'b1, 1'b1, 8'h99, 8'h40, 8'h00, 1'b0, 1'b1, 8'h11);
        op(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h40, 8'h00, 1'b0, 1'b1, 8'h99);
        drain();
        // reverse collision: B writes while A reads
        op(8'h41, 8'h00, 1'b0, 1'b0, 8'h00, 8'h41, 8'h22, 1'b1, 1'b1, 8'h22);
        op(8'h41, 8'h00, 1'b0, 1'b1, 8'h22, 8'h41, 8'h77, 1'b1, 1'b1, 8'h77);
        op(8'h41, 8'h00, 1'b0, 1'b1, 8'h77, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        drain();
        // test 5: dual write to 0xFF, A wins
        op(8'hFF, 8'hAA, 1'b1, 1'b1, 8'hAA, 8'hFF, 8'h55, 1'b1, 1'b1, 8'h55);
        op(8'hFF, 8'h00, 1'b0, 1'b1, 8'hAA, 8'hFF, 8'h00, 1'b0, 1'b1, 8'hAA);
        drain();
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL queue_leftover got %0d/%0d want 0/0", qa.size(), qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
